// File: rtl/sr_cmd_pkg.sv
// rtl/sr_cmd_pkg.sv - shared state encoding and counter width helpers for sr_cmd_gen
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  // Bits needed to hold 0..max_count, never less than one bit
  function automatic int cnt_width(input int max_count);
    int w;
    w = $clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int debounce_width(input int debounce_cycles);
    return cnt_width(debounce_cycles);
  endfunction

  function automatic int lockout_width(input int lockout_cycles);
    return cnt_width(lockout_cycles);
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// rtl/sr_debounce.sv - per-channel synchronizer, debounce counter and rising-edge detect
module sr_debounce
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = debounce_width(DEBOUNCE_CYCLES);
  // Count value at which one more mismatching sample completes the debounce
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  // Two-flop synchronizer for the asynchronous raw request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Flip the debounced level after enough consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt >= C_LAST) begin
      r_level <= ~r_level;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the debounced level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
    end
  end

  assign level = r_level;
  assign rise  = r_level & ~r_level_d;

endmodule

// File: rtl/sr_cmd_gen.sv
// rtl/sr_cmd_gen.sv - arbitrates debounced set/clear requests into clean S/R pulses with lockout
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  output logic S,
  output logic R,
  output logic busy,
  output logic drop,
  output logic conflict
);

  localparam int LW          = lockout_width(LOCKOUT_CYCLES);
  localparam bit HAS_LOCKOUT = (LOCKOUT_CYCLES > 0);
  localparam logic [LW-1:0] LOCK_LOAD = HAS_LOCKOUT ? LW'(LOCKOUT_CYCLES - 1) : '0;

  logic          w_set_level;
  logic          w_set_rise;
  logic          w_clr_level;
  logic          w_clr_rise;
  logic          w_set_edge;
  logic          w_clr_edge;
  logic          w_drop;
  logic          w_conflict;
  state_t        r_state;
  state_t        w_next_state;
  logic [LW-1:0] r_lock_cnt;
  logic          r_s;
  logic          r_r;
  logic          r_busy;
  logic          r_drop;
  logic          r_conflict;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (set_req),
    .level (w_set_level),
    .rise  (w_set_rise)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (clr_req),
    .level (w_clr_level),
    .rise  (w_clr_rise)
  );

  // A command is a rising edge that has settled at the high debounced level
  assign w_set_edge = w_set_rise & w_set_level;
  assign w_clr_edge = w_clr_rise & w_clr_level;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus drop/conflict detection; edges while busy are discarded
  always_comb begin
    w_next_state = r_state;
    w_drop       = 1'b0;
    w_conflict   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_set_edge && w_clr_edge) begin
          w_conflict = 1'b1;
        end else if (w_set_edge) begin
          w_next_state = PULSE_S;
        end else if (w_clr_edge) begin
          w_next_state = PULSE_R;
        end
      end
      PULSE_S, PULSE_R: begin
        w_drop       = w_set_edge | w_clr_edge;
        w_next_state = HAS_LOCKOUT ? LOCKOUT : IDLE;
      end
      LOCKOUT: begin
        w_drop = w_set_edge | w_clr_edge;
        if (r_lock_cnt == '0) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Lockout counter: preloaded outside LOCKOUT, counts down and holds at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_cnt <= '0;
    end else if (r_state != LOCKOUT) begin
      r_lock_cnt <= LOCK_LOAD;
    end else if (r_lock_cnt != '0) begin
      r_lock_cnt <= r_lock_cnt - 1'b1;
    end
  end

  // Output flops decoded from the state register so S and R can never overlap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_drop     <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_s        <= (r_state == PULSE_S);
      r_r        <= (r_state == PULSE_R);
      r_busy     <= (r_state != IDLE);
      r_drop     <= w_drop;
      r_conflict <= w_conflict;
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign busy     = r_busy;
  assign drop     = r_drop;
  assign conflict = r_conflict;

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Command front-end that drives the S/R inputs of the team's `sr_flip_flop`. Takes two raw, asynchronous request lines (set, clear) and synchronizes, debounces and edge-detects each one. It arbitrates between them and emits clean single-cycle `S` / `R` pulses. `S` and `R` are never high together, and a lockout window separates consecutive commands. Sits directly upstream of `sr_flip_flop`, in the same clock domain.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to accept a level change; legal range ≥1.
- `LOCKOUT_CYCLES`, 3: idle cycles enforced after each emitted pulse; 0 is legal and means no lockout.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `set_req` input 1: raw set request (asynchronous, may bounce).
- `clr_req` input 1: raw clear request (asynchronous, may bounce).
- `S` output 1: registered one-cycle set pulse to the flip-flop.
- `R` output 1: registered one-cycle reset pulse to the flip-flop.
- `busy` output 1: high while the FSM is not in IDLE.
- `drop` output 1: one-cycle pulse when an accepted edge is discarded because the FSM is busy.
- `conflict` output 1: one-cycle pulse when set and clear edges arrive in the same cycle while in IDLE.

## Operation
- Per channel, in this order:
  - 2-flop synchronizer.
  - Debounce counter: counts cycles in which the synchronized value differs from the debounced level. It clears when they match. When the count reaches `DEBOUNCE_CYCLES` the debounced level flips and the counter clears.
  - Rising-edge detect on the debounced level gives a one-cycle `*_edge`.
- Falling edges are ignored; only rising debounced edges are commands.
- FSM states are IDLE, PULSE_S, PULSE_R and LOCKOUT:
  - IDLE, set_edge only: go to PULSE_S.
  - IDLE, clr_edge only: go to PULSE_R.
  - IDLE, both edges: stay in IDLE, pulse `conflict`, emit nothing.
  - PULSE_S / PULSE_R: `S` / `R` is high for exactly this one cycle. Next state is LOCKOUT, or IDLE if `LOCKOUT_CYCLES`=0.
  - LOCKOUT: counter runs from `LOCKOUT_CYCLES`-1 down to 0, then the FSM returns to IDLE.
- Any edge seen in PULSE_* or LOCKOUT is discarded and `drop` pulses. Edges are not queued.
- `S` and `R` are driven from flops decoded from the state register; they are mutually exclusive by construction.
- Counter widths: `$clog2(DEBOUNCE_CYCLES+1)` and `$clog2(LOCKOUT_CYCLES+1)`, each with a minimum of 1. Counters saturate and never wrap.

## Timing
- Reset values:
  - `S`, `R`, `busy`, `drop` and `conflict` are 0.
  - Synchronizer flops and debounced levels are 0; counters are 0; state is IDLE.
- Reset assertion forces all outputs low immediately, with no clock needed; this aborts any pulse or lockout in progress.
- A raw input held high through reset release is seen as a fresh rising edge once debounced. It yields one pulse.
- Latency: raw input stable-high is first sampled at edge 0. `S`/`R` is high in the cycle after edge `DEBOUNCE_CYCLES`+3, which is edge 7 with the defaults.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles produce no edge and no pulse.
- `busy` rises in the same cycle as the `S`/`R` pulse. It stays high for 1+`LOCKOUT_CYCLES` cycles.
- Minimum spacing between two emitted pulses is `LOCKOUT_CYCLES`+1 cycles.
- `drop` and `conflict` are registered and appear one cycle after the offending edge.

## Structure
- Package `sr_cmd_pkg` holds:
  - The `state_t` enum (IDLE, PULSE_S, PULSE_R, LOCKOUT).
  - Localparam helper functions for the counter widths.
- Sub-module `sr_debounce` contains the synchronizer, debounce counter and edge detect. It has parameter `DEBOUNCE_CYCLES` and ports `clk`, `rst_n`, `raw`, `level`, `rise`. It is instantiated twice, once per channel.
- The top level holds the FSM, the lockout counter and the output flops.

## Test plan
- Set path: reset, then hold `set_req`=1 for 10 cycles → `S`=1 for exactly one cycle, 7 cycles after the first sample. Check `R`=0 throughout, `busy`=1 for 4 cycles, then 0.
- Glitch reject: pulse `clr_req` high for 2 cycles with `DEBOUNCE_CYCLES`=4 → `R`, `drop` and `conflict` all stay 0.
- Conflict: raise `set_req` and `clr_req` on the same edge → one `conflict` pulse, and `S`=`R`=0 throughout.
- Lockout drop: assert set; once `S` pulses, release `set_req`, then raise `clr_req` so its edge lands in LOCKOUT → `drop`=1 for one cycle, no `R`, and `busy` falls on schedule.
- Reset mid-lockout: assert `rst_n`=0 during LOCKOUT → `busy`, `S` and `R` drop to 0 immediately. With `set_req` still high at release, exactly one `S` pulse follows, 7 cycles later.
- `LOCKOUT_CYCLES`=0: set pulse, then clear edge arriving 1 cycle later → `R` pulse accepted, no `drop`.
